// File: rtl/asr8_seq_ctrl_pkg.sv
// Shared types and constants for the multi-pass arithmetic right-shift sequencer.
package asr8_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Fixed by the 2-bit shamt of the shared ASR8.
   localparam int unsigned STEP_MAX = 3;

   localparam logic [7:0] ALL0 = 8'h00;
   localparam logic [7:0] ALL1 = 8'hFF;

   // Once saturated, further arithmetic shifts cannot change the value.
   function automatic logic is_sat(input logic [7:0] v);
      return (v == ALL0) || (v == ALL1);
   endfunction

endpackage

// File: rtl/asr8_seq_ctrl_asr8.sv
// Combinational 8-bit arithmetic right shifter, 0..3 bits.
module asr8_seq_ctrl_asr8 (
   input  logic [7:0] d_in,
   input  logic [1:0] shamt,
   output logic [7:0] d_out
);

   assign d_out = 8'($signed(d_in) >>> shamt);

endmodule

// File: rtl/asr8_seq_ctrl.sv
// Sequences arithmetic right shifts of 0..2**SHW-1 bits through one 3-bit ASR8,
// with valid/ready handshakes and early exit on saturation.
module asr8_seq_ctrl
   import asr8_seq_ctrl_pkg::*;
#(
   parameter int unsigned SHW = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [7:0]     d_in,
   input  logic [SHW-1:0] shamt,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [7:0]     d_out,
   output logic           busy
);

   state_e         state_q, state_d;
   logic [7:0]     data_q, data_d;
   logic [SHW-1:0] rem_q, rem_d;
   logic           in_ready_q, in_ready_d;
   logic           out_valid_q, out_valid_d;
   logic           busy_q, busy_d;

   logic [1:0]     step;
   logic [7:0]     asr_out;

   // step = min(rem, STEP_MAX), so rem never underflows.
   always_comb begin
      step = (rem_q > SHW'(STEP_MAX)) ? 2'(STEP_MAX) : rem_q[1:0];
   end

   asr8_seq_ctrl_asr8 u_asr8 (
      .d_in  (data_q),
      .shamt (step),
      .d_out (asr_out)
   );

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      rem_d   = rem_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               data_d  = d_in;
               rem_d   = shamt;
               state_d = ((shamt == '0) || is_sat(d_in)) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            data_d = asr_out;
            rem_d  = rem_q - SHW'(step);
            if ((rem_d == '0) || is_sat(asr_out)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Handshake outputs are registered alongside the state they decode.
      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
      busy_d      = (state_d == ST_SHIFT) || (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         data_q      <= ALL0;
         rem_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         rem_q       <= rem_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign d_out     = data_q;

endmodule

// File: tb/tb_asr8_seq_ctrl.sv
// Self-checking bench for asr8_seq_ctrl: directed cases plus randomized requests
// checked against a behavioural arithmetic-shift model.
module tb_asr8_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] d_in;
   logic [3:0] shamt;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] d_out;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   asr8_seq_ctrl #(.SHW(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .d_in      (d_in),
      .shamt     (shamt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d_out     (d_out),
      .busy      (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Result is one signed shift; latency counts passes of up to 3 bits with saturation exit.
   task automatic model(input logic [7:0] d, input logic [3:0] sh,
                        output logic [7:0] res, output int lat);
      int v, r, s, n;
      v   = int'($signed(d));
      res = 8'(v >>> sh);
      if (sh == 0 || d == 8'h00 || d == 8'hFF) begin
         lat = 1;
      end else begin
         r = int'(sh);
         n = 0;
         while (r > 0) begin
            s = (r > 3) ? 3 : r;
            v = v >>> s;
            r = r - s;
            n++;
            if (v == 0 || v == -1) break;
         end
         lat = 1 + n;
      end
   endtask

   task automatic send(input logic [7:0] d, input logic [3:0] sh,
                       output int lat, output bit busy_ok);
      int t;
      t = 0;
      while (!in_ready && t < 50) begin
         step();
         t++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL send_in_ready got=%0b want=1", in_ready);
      end
      in_valid = 1'b1;
      d_in     = d;
      shamt    = sh;
      step();
      in_valid = 1'b0;
      lat      = 1;
      busy_ok  = 1'b1;
      while (!out_valid && lat < 20) begin
         if (busy !== 1'b1 || in_ready !== 1'b0) busy_ok = 1'b0;
         step();
         lat++;
      end
   endtask

   task automatic pop();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      d_in      = 8'h00;
      shamt     = 4'd0;
      step();
      step();
      reset = 1'b0;
      checks++;
      if ({out_valid, in_ready, busy, d_out} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
         failures++;
         $display("FAIL reset_state got ov=%0b ir=%0b busy=%0b d_out=%h want ov=0 ir=1 busy=0 d_out=00",
                  out_valid, in_ready, busy, d_out);
      end
   endtask

   task automatic test_directed();
      logic [7:0] dv [4] = '{8'hAA, 8'hAA, 8'h18, 8'h80};
      logic [3:0] sv [4] = '{4'd0, 4'd5, 4'd3, 4'd15};
      logic [7:0] ev [4] = '{8'hAA, 8'hFD, 8'h03, 8'hFF};
      int         lv [4] = '{1, 3, 2, 4};
      int  lat;
      bit  bok;
      for (int i = 0; i < 4; i++) begin
         send(dv[i], sv[i], lat, bok);
         checks++;
         if (d_out !== ev[i] || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL directed_result[%0d] got d_out=%h ov=%0b want d_out=%h ov=1",
                     i, d_out, out_valid, ev[i]);
         end
         checks++;
         if (lat != lv[i]) begin
            failures++;
            $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, lv[i]);
         end
         pop();
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL directed_release[%0d] got ov=%0b ir=%0b want ov=0 ir=1",
                     i, out_valid, in_ready);
         end
      end
   endtask

   // Intermediate values are visible on d_out while shifting.
   task automatic test_trace();
      logic [7:0] tr [3] = '{8'hAA, 8'hF5, 8'hFD};
      in_valid = 1'b1;
      d_in     = 8'hAA;
      shamt    = 4'd5;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (d_out !== tr[i]) begin
            failures++;
            $display("FAIL trace[%0d] got d_out=%h want=%h", i, d_out, tr[i]);
         end
         if (i < 2) step();
      end
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL trace_done got ov=%0b want=1", out_valid);
      end
      pop();
   endtask

   task automatic test_backpressure();
      int lat;
      bit bok;
      send(8'h7F, 4'd9, lat, bok);
      checks++;
      if (lat != 4 || d_out !== 8'h00) begin
         failures++;
         $display("FAIL bp_result got lat=%0d d_out=%h want lat=4 d_out=00", lat, d_out);
      end
      in_valid = 1'b1;
      d_in     = 8'h55;
      shamt    = 4'd1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if ({out_valid, in_ready, busy, d_out} !== {1'b1, 1'b0, 1'b1, 8'h00}) begin
            failures++;
            $display("FAIL bp_hold[%0d] got ov=%0b ir=%0b busy=%0b d_out=%h want ov=1 ir=0 busy=1 d_out=00",
                     i, out_valid, in_ready, busy, d_out);
         end
      end
      in_valid = 1'b0;
      pop();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL bp_release got ov=%0b ir=%0b busy=%0b want ov=0 ir=1 busy=0",
                  out_valid, in_ready, busy);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL bp_not_queued got ov=%0b busy=%0b want ov=0 busy=0", out_valid, busy);
      end
   endtask

   task automatic test_reset_mid_shift();
      int lat;
      bit bok;
      in_valid = 1'b1;
      d_in     = 8'hAA;
      shamt    = 4'd15;
      step();
      in_valid = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if ({out_valid, in_ready, busy, d_out} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
         failures++;
         $display("FAIL midreset_state got ov=%0b ir=%0b busy=%0b d_out=%h want ov=0 ir=1 busy=0 d_out=00",
                  out_valid, in_ready, busy, d_out);
      end
      send(8'hAA, 4'd5, lat, bok);
      checks++;
      if (d_out !== 8'hFD || lat != 3) begin
         failures++;
         $display("FAIL midreset_after got d_out=%h lat=%0d want d_out=FD lat=3", d_out, lat);
      end
      pop();
   endtask

   task automatic test_random();
      logic [7:0] d, exp_res;
      logic [3:0] sh;
      int         exp_lat, lat, wait_n;
      bit         bok;
      for (int i = 0; i < 60; i++) begin
         d  = 8'($urandom);
         sh = 4'($urandom_range(0, 15));
         if (i % 7 == 0) d = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h7F;
         model(d, sh, exp_res, exp_lat);
         send(d, sh, lat, bok);
         checks++;
         if (d_out !== exp_res || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rand_result d=%h sh=%0d got d_out=%h ov=%0b want d_out=%h ov=1",
                     d, sh, d_out, out_valid, exp_res);
         end
         checks++;
         if (lat != exp_lat) begin
            failures++;
            $display("FAIL rand_latency d=%h sh=%0d got=%0d want=%0d", d, sh, lat, exp_lat);
         end
         checks++;
         if (!bok) begin
            failures++;
            $display("FAIL rand_busy d=%h sh=%0d got busy/in_ready wrong while shifting want busy=1 ir=0",
                     d, sh);
         end
         wait_n = $urandom_range(0, 2);
         for (int k = 0; k < wait_n; k++) step();
         pop();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_trace();
      test_backpressure();
      test_reset_mid_shift();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
